// File: rtl/alu_checker.sv
// alu_checker: in-order scoreboard for an ALU under test.
//   Each issued request (req_valid) has its expected result computed here and
//   queued. Each DUT result (rsp_valid) is compared against the oldest queued
//   expectation. Pass/fail/skip statistics are kept, along with a capture of the
//   first failure and sticky overflow/underflow flags.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   clr                 clears statistics, flags and capture (queue kept)
//   req_valid/opcode/a/b  operation issued to the ALU under test
//   rsp_valid/rsp_y     result produced by the ALU under test
//   pass_cnt/fail_cnt/skip_cnt  saturating statistics
//   pending             number of queued expectations (0..DEPTH)
//   error, ovf, unf     sticky error summary, queue overflow, response underflow
//   fail_valid/opcode/exp/act  first-failure capture
module alu_checker #(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     req_valid,
  input  logic [4:0]               req_opcode,
  input  logic [W-1:0]             req_a,
  input  logic [W-1:0]             req_b,
  input  logic                     rsp_valid,
  input  logic [W-1:0]             rsp_y,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         skip_cnt,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     error,
  output logic                     ovf,
  output logic                     unf,
  output logic                     fail_valid,
  output logic [4:0]               fail_opcode,
  output logic [W-1:0]             fail_exp,
  output logic [W-1:0]             fail_act
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SHW = $clog2(W);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SLL  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SRL  = 5'b00100;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_SLTU = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BEQ  = 5'b01010;
  localparam logic [4:0] OP_LUI  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_BLT  = 5'b01101;
  localparam logic [4:0] OP_BGE  = 5'b01110;
  localparam logic [4:0] OP_BLTU = 5'b10000;
  localparam logic [4:0] OP_BGEU = 5'b10001;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // expected-result model
  logic [SHW-1:0] w_sh;
  logic [W-1:0]   w_exp;
  logic           w_chk;

  assign w_sh = req_b[SHW-1:0];

  always_comb begin
    w_exp = '0;
    w_chk = 1'b1;
    case (req_opcode)
      OP_ADD:  w_exp = req_a + req_b;
      OP_SUB:  w_exp = req_a - req_b;
      OP_SLL:  w_exp = req_a << w_sh;
      OP_XOR:  w_exp = req_a ^ req_b;
      OP_SRL:  w_exp = req_a >> w_sh;
      OP_SRA:  w_exp = $signed(req_a) >>> w_sh;
      OP_OR:   w_exp = req_a | req_b;
      OP_AND:  w_exp = req_a & req_b;
      OP_SLTU: w_exp = {{(W-1){1'b0}}, (req_a < req_b)};
      OP_BNE:  w_exp = {{(W-1){1'b0}}, (req_a != req_b)};
      OP_BEQ:  w_exp = {{(W-1){1'b0}}, (req_a == req_b)};
      OP_LUI:  w_exp = req_b;
      OP_MUL:  w_exp = req_a * req_b;
      OP_BLT:  w_exp = {{(W-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
      OP_BGE:  w_exp = {{(W-1){1'b0}}, ($signed(req_a) >= $signed(req_b))};
      OP_BLTU: w_exp = {{(W-1){1'b0}}, (req_a < req_b)};
      OP_BGEU: w_exp = {{(W-1){1'b0}}, (req_a >= req_b)};
      default: w_chk = 1'b0;
    endcase
  end

  // expectation FIFO
  logic [4:0]   r_op_mem  [DEPTH];
  logic [W-1:0] r_exp_mem [DEPTH];
  logic         r_chk_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic w_full, w_empty, w_pop, w_push;
  logic [4:0]   w_h_op;
  logic [W-1:0] w_h_exp;
  logic         w_h_chk;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = rsp_valid & ~w_empty;
  // a pop frees the head slot, so a full queue still accepts a same-cycle push
  assign w_push  = req_valid & (~w_full | w_pop);
  assign w_h_op  = r_op_mem[r_rptr];
  assign w_h_exp = r_exp_mem[r_rptr];
  assign w_h_chk = r_chk_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_op_mem[r_wptr]  <= req_opcode;
      r_exp_mem[r_wptr] <= w_exp;
      r_chk_mem[r_wptr] <= w_chk;
    end
  end

  // statistics, flags and capture
  logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt, r_skip_cnt;
  logic             r_ovf, r_unf, r_fail_valid;
  logic [4:0]       r_fail_opcode;
  logic [W-1:0]     r_fail_exp, r_fail_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_pass_cnt    <= '0;
      r_fail_cnt    <= '0;
      r_skip_cnt    <= '0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
      r_fail_valid  <= 1'b0;
      r_fail_opcode <= '0;
      r_fail_exp    <= '0;
      r_fail_act    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (clr) begin
        // a coincident pop is consumed but deliberately not scored
        r_pass_cnt    <= '0;
        r_fail_cnt    <= '0;
        r_skip_cnt    <= '0;
        r_ovf         <= 1'b0;
        r_unf         <= 1'b0;
        r_fail_valid  <= 1'b0;
        r_fail_opcode <= '0;
        r_fail_exp    <= '0;
        r_fail_act    <= '0;
      end else begin
        if (req_valid && w_full && !w_pop) r_ovf <= 1'b1;
        if (rsp_valid && w_empty)          r_unf <= 1'b1;
        if (w_pop) begin
          if (!w_h_chk) begin
            if (r_skip_cnt != '1) r_skip_cnt <= r_skip_cnt + 1'b1;
          end else if (w_h_exp == rsp_y) begin
            if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
          end else begin
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
            if (!r_fail_valid) begin
              r_fail_valid  <= 1'b1;
              r_fail_opcode <= w_h_op;
              r_fail_exp    <= w_h_exp;
              r_fail_act    <= rsp_y;
            end
          end
        end
      end
    end
  end

  assign pass_cnt    = r_pass_cnt;
  assign fail_cnt    = r_fail_cnt;
  assign skip_cnt    = r_skip_cnt;
  assign pending     = r_count;
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign fail_valid  = r_fail_valid;
  assign fail_opcode = r_fail_opcode;
  assign fail_exp    = r_fail_exp;
  assign fail_act    = r_fail_act;
  assign error       = r_fail_valid | r_ovf | r_unf;

endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: directed bench for alu_checker. Stimulus pushes expected
// statistics snapshots into a queue; a monitor pops one per counter update.
module tb_alu_checker;
  localparam int W     = 64;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst, clr;
  logic             req_valid;
  logic [4:0]       req_opcode;
  logic [W-1:0]     req_a, req_b;
  logic             rsp_valid;
  logic [W-1:0]     rsp_y;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, skip_cnt;
  logic [$clog2(DEPTH):0] pending;
  logic             error, ovf, unf, fail_valid;
  logic [4:0]       fail_opcode;
  logic [W-1:0]     fail_exp, fail_act;

  alu_checker #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .pending(pending), .error(error), .ovf(ovf), .unf(unf),
    .fail_valid(fail_valid), .fail_opcode(fail_opcode),
    .fail_exp(fail_exp), .fail_act(fail_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned p;
    int unsigned f;
    int unsigned s;
  } cnt_t;

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
    int          kind;
  } vec_t;

  cnt_t sb[$];
  vec_t vt[$];
  cnt_t m_e;
  int n_checks = 0;
  int n_fails  = 0;
  int unsigned e_p = 0, e_f = 0, e_s = 0;
  logic [CNT_W-1:0] m_p = '0, m_f = '0, m_s = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
  endtask

  // kind: 0 pass, 1 fail, 2 skip
  task automatic expect_rsp(input logic [63:0] y, input int kind);
    cnt_t c;
    rsp_valid = 1'b1;
    rsp_y     = y;
    if (kind == 0) e_p++;
    else if (kind == 1) e_f++;
    else e_s++;
    c.p = e_p; c.f = e_f; c.s = e_s;
    sb.push_back(c);
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    e_p = 0; e_f = 0; e_s = 0;
  endtask

  // monitor: every nonzero change of the statistics consumes one expectation
  always @(negedge clk) begin
    if ({pass_cnt, fail_cnt, skip_cnt} != {m_p, m_f, m_s}) begin
      if (pass_cnt != '0 || fail_cnt != '0 || skip_cnt != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_count_update: got p=%0d f=%0d s=%0d, required no update",
                   pass_cnt, fail_cnt, skip_cnt);
        end else begin
          m_e = sb.pop_front();
          chk("mon_pass_cnt", 64'(pass_cnt), 64'(m_e.p));
          chk("mon_fail_cnt", 64'(fail_cnt), 64'(m_e.f));
          chk("mon_skip_cnt", 64'(skip_cnt), 64'(m_e.s));
        end
      end
      m_p = pass_cnt;
      m_f = fail_cnt;
      m_s = skip_cnt;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pass"},    64'(pass_cnt), 0);
    chk({tag, "_fail"},    64'(fail_cnt), 0);
    chk({tag, "_skip"},    64'(skip_cnt), 0);
    chk({tag, "_pending"}, 64'(pending), 0);
    chk({tag, "_error"},   64'(error), 0);
    chk({tag, "_ovf"},     64'(ovf), 0);
    chk({tag, "_unf"},     64'(unf), 0);
    chk({tag, "_fvalid"},  64'(fail_valid), 0);
    chk({tag, "_fop"},     64'(fail_opcode), 0);
    chk({tag, "_fexp"},    fail_exp, 0);
    chk({tag, "_fact"},    fail_act, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
    rsp_valid = 1'b0; rsp_y = '0;

    vt.push_back('{5'd2,  64'd1, 64'd65, 64'd2, 0});
    vt.push_back('{5'd4,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 0});
    vt.push_back('{5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 0});
    vt.push_back('{5'd8,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0});
    vt.push_back('{5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0});
    vt.push_back('{5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0});
    vt.push_back('{5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0});
    vt.push_back('{5'd11, 64'd5, 64'h1234, 64'h1234, 0});
    vt.push_back('{5'd6,  64'hF0, 64'h0F, 64'hFF, 0});
    vt.push_back('{5'd7,  64'hFF, 64'h3C, 64'h3C, 0});
    vt.push_back('{5'd9,  64'd4, 64'd5, 64'd1, 0});
    vt.push_back('{5'd1,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0});
    vt.push_back('{5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 0});
    vt.push_back('{5'd5,  64'h7000_0000_0000_0000, 64'h44, 64'h0700_0000_0000_0000, 0});
    vt.push_back('{5'd10, 64'd3, 64'd4, 64'd0, 0});
    vt.push_back('{5'd15, 64'd1, 64'd2, 64'd0, 2});
    vt.push_back('{5'd18, 64'd10, 64'd2, 64'd12345, 2});
    vt.push_back('{5'd20, 64'd10, 64'd3, 64'd7, 2});

    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;

    // Scenario 1: ADD
    send_req(5'd0, 64'd5, 64'd7); tick; req_valid = 1'b0;
    chk("s1_pending_after_req", 64'(pending), 1);
    expect_rsp(64'd12, 0); tick; rsp_valid = 1'b0;
    chk("s1_pending_after_rsp", 64'(pending), 0);
    chk("s1_error", 64'(error), 0);

    // Scenario 2: SRA pass, BLT fail
    send_req(5'd5, 64'h8000_0000_0000_0000, 64'd4); tick; req_valid = 1'b0;
    expect_rsp(64'hF800_0000_0000_0000, 0); tick; rsp_valid = 1'b0;
    chk("s2_fvalid_before", 64'(fail_valid), 0);
    send_req(5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); tick; req_valid = 1'b0;
    expect_rsp(64'd0, 1); tick; rsp_valid = 1'b0;
    chk("s2_fvalid", 64'(fail_valid), 1);
    chk("s2_fop", 64'(fail_opcode), 64'b01101);
    chk("s2_fexp", fail_exp, 1);
    chk("s2_fact", fail_act, 0);
    chk("s2_error", 64'(error), 1);
    do_clr;
    chk("s2_clr_error", 64'(error), 0);
    chk("s2_clr_fexp", fail_exp, 0);

    // Scenario 3: overflow, then drain (first pop paired with a push while full)
    for (int i = 0; i <= DEPTH; i++) begin
      send_req(5'd0, 64'(i), 64'(10 * i)); tick;
    end
    req_valid = 1'b0;
    chk("s3_ovf", 64'(ovf), 1);
    chk("s3_pending_full", 64'(pending), DEPTH);
    chk("s3_error", 64'(error), 1);
    do_clr;
    chk("s3_clr_ovf", 64'(ovf), 0);
    chk("s3_clr_keeps_fifo", 64'(pending), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      expect_rsp(64'(11 * i), 0);
      if (i == 0) send_req(5'd0, 64'd100, 64'd1);
      tick;
      req_valid = 1'b0;
      if (i == 0) begin
        chk("s3_pushpop_full_pending", 64'(pending), DEPTH);
        chk("s3_pushpop_full_ovf", 64'(ovf), 0);
      end
    end
    rsp_valid = 1'b0;
    chk("s3_pass_depth", 64'(pass_cnt), DEPTH);
    chk("s3_pending_one", 64'(pending), 1);
    expect_rsp(64'd101, 0); tick; rsp_valid = 1'b0;
    chk("s3_pending_empty", 64'(pending), 0);
    do_clr;

    // Scenario 4: underflow with same-cycle push
    send_req(5'd10, 64'd3, 64'd3);
    rsp_valid = 1'b1; rsp_y = 64'd1;
    tick; req_valid = 1'b0; rsp_valid = 1'b0;
    chk("s4_unf", 64'(unf), 1);
    chk("s4_error", 64'(error), 1);
    chk("s4_pass", 64'(pass_cnt), 0);
    chk("s4_fail", 64'(fail_cnt), 0);
    chk("s4_skip", 64'(skip_cnt), 0);
    chk("s4_pending", 64'(pending), 1);
    expect_rsp(64'd1, 0); tick; rsp_valid = 1'b0;
    chk("s4_pending_after", 64'(pending), 0);
    do_clr;
    chk("s4_clr_unf", 64'(unf), 0);

    // Scenario 5: opcode table, skips, first-failure capture
    foreach (vt[k]) begin
      send_req(vt[k].op, vt[k].a, vt[k].b); tick; req_valid = 1'b0;
      expect_rsp(vt[k].y, vt[k].kind); tick; rsp_valid = 1'b0;
    end
    chk("s5_no_fail", 64'(fail_valid), 0);
    chk("s5_no_error", 64'(error), 0);
    send_req(5'd3, 64'hF0, 64'h0F); tick; req_valid = 1'b0;
    expect_rsp(64'd0, 1); tick; rsp_valid = 1'b0;
    chk("s5_fop", 64'(fail_opcode), 3);
    chk("s5_fexp", fail_exp, 64'hFF);
    send_req(5'd1, 64'd5, 64'd7); tick; req_valid = 1'b0;
    expect_rsp(64'd1, 1); tick; rsp_valid = 1'b0;
    chk("s5_fail_cnt2", 64'(fail_cnt), 2);
    chk("s5_keep_fop", 64'(fail_opcode), 3);
    chk("s5_keep_fexp", fail_exp, 64'hFF);
    chk("s5_keep_fact", fail_act, 0);

    // Scenario 6: clr with queued entries, clr+pop, reset mid-stream
    do_clr;
    send_req(5'd0, 64'd1, 64'd1); tick;
    send_req(5'd7, 64'hF, 64'h3); tick;
    req_valid = 1'b0;
    do_clr;
    chk("s6_clr_pending", 64'(pending), 2);
    chk("s6_clr_error", 64'(error), 0);
    chk("s6_clr_pass", 64'(pass_cnt), 0);
    chk("s6_clr_fail", 64'(fail_cnt), 0);
    expect_rsp(64'd2, 0); tick;
    expect_rsp(64'd3, 0); tick;
    rsp_valid = 1'b0;
    chk("s6_pending_drained", 64'(pending), 0);

    send_req(5'd0, 64'd2, 64'd2); tick; req_valid = 1'b0;
    send_req(5'd0, 64'd4, 64'd4);
    rsp_valid = 1'b1; rsp_y = 64'd0; clr = 1'b1;
    tick;
    clr = 1'b0; rsp_valid = 1'b0; req_valid = 1'b0;
    e_p = 0; e_f = 0; e_s = 0;
    chk("s6_clrpop_pending", 64'(pending), 1);
    chk("s6_clrpop_fail", 64'(fail_cnt), 0);
    chk("s6_clrpop_fvalid", 64'(fail_valid), 0);
    expect_rsp(64'd8, 0); tick; rsp_valid = 1'b0;

    send_req(5'd0, 64'd1, 64'd1); tick; req_valid = 1'b0;
    expect_rsp(64'd0, 1); tick; rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_req(5'd0, 64'(i), 64'd1); tick;
    end
    rst = 1'b1;
    rsp_valid = 1'b1; rsp_y = 64'd0;
    tick;
    rst = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0;
    e_p = 0; e_f = 0; e_s = 0;
    chk_all_zero("s6_rst");
    rsp_valid = 1'b1; rsp_y = 64'd1;
    tick; rsp_valid = 1'b0;
    chk("s6_post_rst_unf", 64'(unf), 1);
    chk("s6_post_rst_pending", 64'(pending), 0);
    chk("s6_post_rst_pass", 64'(pass_cnt), 0);
    chk("s6_post_rst_skip", 64'(skip_cnt), 0);

    tick; tick;
    chk("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 The block SHALL have these parameters: W, default 64, operand/result width. DEPTH, default 8, number of in-flight expectations, a power of two >= 2. CNT_W, default 32, statistics counter width.
REQ-002 The block SHALL have these ports, one clock domain; reset is synchronous and active-high:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear of statistics and error state
req_valid  in  1  ALU operation issued this cycle
req_opcode  in  5  ALU opcode
req_a, req_b  in  W  operands
rsp_valid  in  1  DUT result valid this cycle
rsp_y  in  W  DUT result
pass_cnt, fail_cnt, skip_cnt  out  CNT_W  statistics
pending  out  clog2(DEPTH)+1  expectations queued
error  out  1  sticky: any fail, overflow or underflow
ovf, unf  out  1  sticky expectation overflow / response underflow
fail_valid  out  1  first-failure capture valid
fail_opcode  out  5  opcode of first failure
fail_exp, fail_act  out  W  expected/actual of first failure

Function
REQ-003 On req_valid the block SHALL compute the expected result combinationally from the request and push {opcode, expected, checked} into an in-order FIFO of DEPTH entries.
REQ-004 Expected values SHALL be: 00000 A+B; 00001 A-B; 00010 A<<sh; 00011 A^B; 00100 A>>sh (logical); 00101 A>>>sh (arithmetic, sign-filled); 00110 A|B; 00111 A&B; 01000 SLTU (A<B unsigned ? 1 : 0); 01001 BNE (A!=B ? 1 : 0); 01010 BEQ (A==B ? 1 : 0); 01011 LUI (B); 01100 MUL (low W bits of A*B); 01101 BLT (signed A<B ? 1 : 0); 01110 BGE (signed A>=B ? 1 : 0); 10000 BLTU (unsigned A<B ? 1 : 0); 10001 BGEU (unsigned A>=B ? 1 : 0).
REQ-005 sh SHALL be B[clog2(W)-1:0]; arithmetic results SHALL wrap modulo 2^W; 1-bit results SHALL be zero-extended to W.
REQ-006 Any other opcode, including DIV 10010 and REM 10100, SHALL be pushed with checked=0.
REQ-007 On rsp_valid with pending>0, the block SHALL pop the head entry and compare it with rsp_y. If checked=1 and equal, pass_cnt SHALL increment. If checked=1 and not equal, fail_cnt SHALL increment. If checked=0, skip_cnt SHALL increment.
REQ-008 Counter and flag updates SHALL be visible on the rising edge after the cycle in which rsp_valid was sampled (1-cycle latency).
REQ-009 Counters SHALL saturate at 2^CNT_W-1.
REQ-010 On the first failure since rst/clr, fail_valid SHALL set and fail_opcode/fail_exp/fail_act SHALL capture that entry. Later failures SHALL NOT overwrite the capture.
REQ-011 error SHALL be the OR of fail_valid, ovf and unf, and SHALL be held until rst or clr.
REQ-012 Push and pop in the same cycle SHALL both occur and pending SHALL be unchanged. When full, a simultaneous push+pop SHALL NOT set ovf.
REQ-013 A push while full without a pop SHALL drop the request and set ovf. FIFO contents SHALL be unchanged.
REQ-014 rsp_valid with pending=0 SHALL set unf and update no counter. A same-cycle req_valid SHALL still push, and its expectation SHALL NOT be compared with that rsp_y.
REQ-015 FIFO read/write pointers SHALL wrap modulo DEPTH. pending SHALL range 0..DEPTH.
REQ-016 clr SHALL zero all counters, ovf, unf and fail_valid, and clear the capture registers. clr SHALL NOT flush the FIFO.
REQ-017 When clr coincides with a pop, the pop SHALL still occur but its result SHALL NOT be counted or captured. A same-cycle push SHALL proceed.

Reset
REQ-018 When rst is high at a clock edge, all outputs SHALL be zero, the FIFO SHALL be emptied (pointers 0, pending 0), and req/rsp inputs SHALL be ignored. rst SHALL take priority over clr.
REQ-019 Reset asserted mid-operation SHALL discard all queued expectations. Responses arriving after reset release with no new request SHALL raise unf.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Scenario 1: ADD A=5 B=7, rsp_y=12 one cycle later -> pass_cnt=1, error=0, pending back to 0.
- Scenario 2: SRA A=0x8000_0000_0000_0000 B=4, rsp_y=0xF800_0000_0000_0000 -> pass. Then BLT A=-1 B=1, rsp_y=0 -> fail_cnt=1, fail_exp=1, fail_act=0, fail_opcode=01101.
- Scenario 3: DEPTH+1 back-to-back requests with no responses -> ovf=1, pending=DEPTH. DEPTH correct responses -> pass_cnt=DEPTH.
- Scenario 4: rsp_valid with pending=0 together with req BEQ A=B=3 -> unf=1, counters 0, pending=1. Next cycle rsp_y=1 -> pass_cnt=1.
- Scenario 5: DIV request, rsp_y=anything -> skip_cnt=1, no fail. Second failure after a first -> capture unchanged, fail_cnt=2.
- Scenario 6: clr with two entries queued -> counters and flags 0, pending=2, and the following two correct responses count as passes. rst mid-stream -> pending=0, all outputs 0.
